// File: rtl/mips_regfile_p_if.sv
// rtl/mips_regfile_p_if.sv - register file read/write/scoreboard bus
interface mips_regfile_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [DATA_W-1:0] R_Data_A;
  logic [DATA_W-1:0] R_Data_B;
  logic              Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Write_Reg_2;
  logic [ADDR_W-1:0] W_Addr_2;
  logic [DATA_W-1:0] W_Data_2;
  logic              Busy_Set;
  logic [ADDR_W-1:0] Busy_Addr;
  logic              Busy_A;
  logic              Busy_B;
  logic [ADDR_W:0]   Busy_Count;

  modport master (
    output R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data,
           Write_Reg_2, W_Addr_2, W_Data_2, Busy_Set, Busy_Addr,
    input  R_Data_A, R_Data_B, Busy_A, Busy_B, Busy_Count
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data,
           Write_Reg_2, W_Addr_2, W_Data_2, Busy_Set, Busy_Addr,
    output R_Data_A, R_Data_B, Busy_A, Busy_B, Busy_Count
  );
endinterface

// File: rtl/mips_regfile_p.sv
// rtl/mips_regfile_p.sv - two-write, two-read MIPS register file with busy scoreboard
module mips_regfile_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  mips_regfile_p_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;

  logic              we0;
  logic              we1;
  logic              bset;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  // Register 0 is hardwired: any access aimed at it is dropped here.
  assign we0  = !reset && bus.Write_Reg   && (bus.W_Addr    != '0);
  assign we1  = !reset && bus.Write_Reg_2 && (bus.W_Addr_2  != '0);
  assign bset = !reset && bus.Busy_Set    && (bus.Busy_Addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      // Port 0 is assigned last so it wins an address collision.
      if (we1) regs_q[bus.W_Addr_2] <= bus.W_Data_2;
      if (we0) regs_q[bus.W_Addr]   <= bus.W_Data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (we1)  busy_d[bus.W_Addr_2]  = 1'b0;
    if (we0)  busy_d[bus.W_Addr]    = 1'b0;
    if (bset) busy_d[bus.Busy_Addr] = 1'b1;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_comb begin
    rdata_a = regs_q[bus.R_Addr_A];
    if (BYPASS != 0) begin
      if (we1 && (bus.W_Addr_2 == bus.R_Addr_A)) rdata_a = bus.W_Data_2;
      if (we0 && (bus.W_Addr   == bus.R_Addr_A)) rdata_a = bus.W_Data;
    end
    if (bus.R_Addr_A == '0) rdata_a = '0;
  end

  always_comb begin
    rdata_b = regs_q[bus.R_Addr_B];
    if (BYPASS != 0) begin
      if (we1 && (bus.W_Addr_2 == bus.R_Addr_B)) rdata_b = bus.W_Data_2;
      if (we0 && (bus.W_Addr   == bus.R_Addr_B)) rdata_b = bus.W_Data;
    end
    if (bus.R_Addr_B == '0) rdata_b = '0;
  end

  assign bus.R_Data_A   = rdata_a;
  assign bus.R_Data_B   = rdata_b;
  assign bus.Busy_A     = (bus.R_Addr_A != '0) && busy_q[bus.R_Addr_A];
  assign bus.Busy_B     = (bus.R_Addr_B != '0) && busy_q[bus.R_Addr_B];
  assign bus.Busy_Count = count_q;
endmodule

// File: tb/tb_mips_regfile_p.sv
// tb/tb_mips_regfile_p.sv - directed self-checking bench, bypass and no-bypass instances side by side
`timescale 1ns/1ps
module tb_mips_regfile_p;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  ra = '0, rb = '0, wa = '0, wa2 = '0, ba = '0;
  logic [31:0] wd = '0, wd2 = '0;
  logic        we = 1'b0, we2 = 1'b0, bs = 1'b0;

  int errors = 0;
  int checks = 0;

  mips_regfile_p_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  mips_regfile_p_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  assign bus1.R_Addr_A = ra;  assign bus0.R_Addr_A = ra;
  assign bus1.R_Addr_B = rb;  assign bus0.R_Addr_B = rb;
  assign bus1.Write_Reg = we; assign bus0.Write_Reg = we;
  assign bus1.W_Addr = wa;    assign bus0.W_Addr = wa;
  assign bus1.W_Data = wd;    assign bus0.W_Data = wd;
  assign bus1.Write_Reg_2 = we2; assign bus0.Write_Reg_2 = we2;
  assign bus1.W_Addr_2 = wa2; assign bus0.W_Addr_2 = wa2;
  assign bus1.W_Data_2 = wd2; assign bus0.W_Data_2 = wd2;
  assign bus1.Busy_Set = bs;  assign bus0.Busy_Set = bs;
  assign bus1.Busy_Addr = ba; assign bus0.Busy_Addr = ba;

  mips_regfile_p #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  mips_regfile_p #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  // Architectural model: register contents and the set of busy registers.
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we2 && wa2 != 0) begin m_reg[wa2] = wd2; m_busy[wa2] = 1'b0; end
      if (we  && wa  != 0) begin m_reg[wa]  = wd;  m_busy[wa]  = 1'b0; end
      if (bs  && ba  != 0) m_busy[ba] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (reset || a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    if (byp && we2 && wa2 == a) return wd2;
    return m_reg[a];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp byp A", bus1.R_Data_A, exp_read(ra, 1'b1));
    check("cmp byp B", bus1.R_Data_B, exp_read(rb, 1'b1));
    check("cmp nobyp A", bus0.R_Data_A, exp_read(ra, 1'b0));
    check("cmp nobyp B", bus0.R_Data_B, exp_read(rb, 1'b0));
    check("cmp busyA", {31'b0, bus1.Busy_A}, {31'b0, m_busy[ra]});
    check("cmp busyB", {31'b0, bus0.Busy_B}, {31'b0, m_busy[rb]});
    check("cmp count byp", {26'b0, bus1.Busy_Count}, exp_count());
    check("cmp count nobyp", {26'b0, bus0.Busy_Count}, exp_count());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; we2 = 1'b0; bs = 1'b0;
  endtask

  initial begin
    #12;
    check("reset dataA", bus1.R_Data_A, 32'h0);
    check("reset count", {26'b0, bus1.Busy_Count}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    cyc(); idle(); ra = 5'd5; #1;
    check("r5 byp", bus1.R_Data_A, 32'hDEADBEEF);
    check("r5 nobyp", bus0.R_Data_A, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = 5'd0;
    cyc(); idle(); #1;
    check("r0 zero", bus1.R_Data_A, 32'h0);

    we = 1'b1; wa = 5'd7; wd = 32'h0A0A0A0A;
    cyc();
    wd = 32'h11111111; we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h22222222; rb = 5'd7; #1;
    check("r7 bypass", bus1.R_Data_B, 32'h11111111);
    check("r7 no bypass", bus0.R_Data_B, 32'h0A0A0A0A);
    cyc(); idle(); #1;
    check("r7 after byp", bus1.R_Data_B, 32'h11111111);
    check("r7 after nobyp", bus0.R_Data_B, 32'h11111111);

    bs = 1'b1; ba = 5'd3; cyc();
    ba = 5'd9; cyc(); idle(); ra = 5'd3; #1;
    check("busy count 2", {26'b0, bus1.Busy_Count}, 32'd2);
    check("busy r3", {31'b0, bus1.Busy_A}, 32'd1);
    we2 = 1'b1; wa2 = 5'd3; wd2 = 32'h33333333;
    cyc(); idle(); #1;
    check("busy count 1", {26'b0, bus0.Busy_Count}, 32'd1);
    check("busy r3 clr", {31'b0, bus0.Busy_A}, 32'd0);

    bs = 1'b1; ba = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h44444444;
    cyc(); idle(); ra = 5'd4; #1;
    check("r4 data", bus1.R_Data_A, 32'h44444444);
    check("r4 busy", {31'b0, bus1.Busy_A}, 32'd1);
    check("r4 count", {26'b0, bus1.Busy_Count}, 32'd2);
    bs = 1'b1; ba = 5'd4; cyc();
    ba = 5'd0; cyc(); idle(); ra = 5'd0; #1;
    check("r4 recount", {26'b0, bus1.Busy_Count}, 32'd2);
    check("busy r0", {31'b0, bus1.Busy_A}, 32'd0);

    for (int i = 1; i < 32; i++) begin
      idle();
      if (i % 2 == 1) begin we = 1'b1; wa = 5'(i); wd = 32'h10000000 + 32'(i) * 32'h101; end
      else begin we2 = 1'b1; wa2 = 5'(i); wd2 = 32'h10000000 + 32'(i) * 32'h101; end
      cyc();
    end
    idle();
    for (int i = 21; i <= 30; i++) begin
      bs = 1'b1; ba = 5'(i); cyc();
    end
    idle(); ra = 5'd31; rb = 5'd22; #1;
    check("r31 load", bus1.R_Data_A, 32'h10001F1F);
    check("load count", {26'b0, bus1.Busy_Count}, 32'd10);
    check("r22 busy", {31'b0, bus0.Busy_B}, 32'd1);

    @(posedge clk); #2 reset = 1'b1; #0.5;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #0.1;
      check("rst A", bus1.R_Data_A, 32'h0);
      check("rst B", bus0.R_Data_B, 32'h0);
    end
    check("rst count", {26'b0, bus1.Busy_Count}, 32'd0);
    check("rst busyA", {31'b0, bus1.Busy_A}, 32'd0);

    we = 1'b1; wa = 5'd6; wd = 32'h66666666; bs = 1'b1; ba = 5'd6;
    cyc(); idle(); #1;
    reset = 1'b0; ra = 5'd6; #1;
    check("rst ignore wr", bus1.R_Data_A, 32'h0);
    check("rst ignore busy", {26'b0, bus1.Busy_Count}, 32'd0);
    we = 1'b1; wa = 5'd6; wd = 32'h66666666;
    cyc(); idle(); #1;
    check("post rst wr", bus1.R_Data_A, 32'h66666666);

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_regfile_p.md
MIPS_REGFILE_P -- requirements
Module: mips_regfile_p

Interface
REQ-001 Parameter: DATA_W, default 32, register and data-port width in bits.
REQ-002 Parameter: ADDR_W, default 5, register address width; depth is 2^ADDR_W.
REQ-003 Parameter: BYPASS, default 1; 1 enables same-cycle write-to-read forwarding, 0 disables it.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 R_Addr_A  input  ADDR_W  read port A address (rs).
REQ-007 R_Addr_B  input  ADDR_W  read port B address (rt).
REQ-008 R_Data_A  output  DATA_W  read port A data.
REQ-009 R_Data_B  output  DATA_W  read port B data.
REQ-010 Write_Reg  input  1  write port 0 enable (ALU writeback).
REQ-011 W_Addr  input  ADDR_W  write port 0 address.
REQ-012 W_Data  input  DATA_W  write port 0 data.
REQ-013 Write_Reg_2  input  1  write port 1 enable (late/load writeback).
REQ-014 W_Addr_2  input  ADDR_W  write port 1 address.
REQ-015 W_Data_2  input  DATA_W  write port 1 data.
REQ-016 Busy_Set  input  1  mark Busy_Addr as having an in-flight producer.
REQ-017 Busy_Addr  input  ADDR_W  register to mark busy.
REQ-018 Busy_A  output  1  scoreboard bit of R_Addr_A.
REQ-019 Busy_B  output  1  scoreboard bit of R_Addr_B.
REQ-020 Busy_Count  output  ADDR_W+1  number of registers currently busy.

Function
REQ-021 Reads SHALL be combinational: R_Data_x = REG[R_Addr_x], zero latency.
REQ-022 Register 0 SHALL always read 0; writes and Busy_Set targeting address 0 SHALL be ignored.
REQ-023 Enabled writes SHALL update the register on the rising clk edge; result visible on reads the following cycle.
REQ-024 Both write ports to the same nonzero address in one cycle: port 0 (W_Data) SHALL win.
REQ-025 With BYPASS=1, a read whose address equals an enabled same-cycle nonzero write address SHALL return that write data (port 0 priority per REQ-024); with BYPASS=0 it SHALL return the stored old value.
REQ-026 Scoreboard: one busy bit per register; Busy_Set to a nonzero address SHALL set the bit at the next edge.
REQ-027 An enabled write on either port SHALL clear the busy bit of its address at the next edge.
REQ-028 Busy_Set and a write to the same address in one cycle: set SHALL win (new producer supersedes).
REQ-029 Busy_Set to an already-busy address SHALL leave it busy; Busy_Count SHALL not double-count.
REQ-030 Busy_A/Busy_B SHALL reflect the registered busy bits (no bypass); Busy_x for address 0 SHALL be 0.
REQ-031 Busy_Count SHALL be registered, equal to popcount of busy bits after each edge, range 0..2^ADDR_W-1.

Reset
REQ-032 reset high SHALL immediately, without clk, clear all registers, all busy bits and Busy_Count to 0; R_Data_A/B, Busy_A/B then read 0.
REQ-033 While reset is high, writes and Busy_Set SHALL be ignored; normal operation resumes on the first rising clk edge after reset falls.

Verification
REQ-034 Reset, then write 32'hDEADBEEF to r5 via port 0, read r5 on A next cycle -> R_Data_A=32'hDEADBEEF; write r0=32'hFFFFFFFF -> R_Data_A(addr 0)=0.
REQ-035 Same cycle port0 r7=32'h11111111, port1 r7=32'h22222222 -> r7 reads 32'h11111111 next cycle; with BYPASS=1 R_Data_B(addr 7) shows 32'h11111111 in the write cycle, with BYPASS=0 shows prior value.
REQ-036 Busy_Set r3, then r9 -> Busy_Count=2, Busy_A(addr 3)=1; port1 write r3 -> Busy_Count=1, Busy_A=0.
REQ-037 Busy_Set r4 and port0 write r4 same cycle -> r4 data updated, Busy for r4=1, Busy_Count incremented by 1; repeat Busy_Set r4 -> count unchanged.
REQ-038 Load r1..r31 with nonzero values and mark 10 busy, assert reset asynchronously mid-cycle -> all R_Data=0, Busy_Count=0 before next clk edge.
